// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared state and pattern-mode encodings for the memory fill engine
package mem_fill_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, WAIT, CHECK, FAIL, DONE} state_e;
  typedef enum logic [1:0] {MODE_IDENTITY, MODE_CONSTANT, MODE_RAMP, MODE_REVERSE} mode_e;
endpackage

// File: rtl/fill_pattern_gen.sv
// fill_pattern_gen: combinational word-index to fill-pattern mapping, all arithmetic mod 2**DATA_W
module fill_pattern_gen
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] fill_value_i,
  input  logic [ADDR_W-1:0] idx_i,
  output logic [DATA_W-1:0] data_o
);
  localparam logic [DATA_W-1:0] LAST = DATA_W'(DEPTH - 1);
  logic [DATA_W-1:0] idx;
  assign idx = DATA_W'(idx_i);
  always_comb begin
    data_o = mode_i == MODE_IDENTITY ? idx :
             mode_i == MODE_CONSTANT ? fill_value_i :
             mode_i == MODE_RAMP     ? fill_value_i + idx :
                                       LAST - idx;
  end
endmodule

// File: rtl/mem_fill_engine.sv
// mem_fill_engine: fills a synchronous RAM with a pattern, optionally verifying each word with bounded retries
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 1,
  parameter int VERIFY    = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int WW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] idx_q, idx_d, err_addr_q, err_addr_d, addr_q;
  logic [DATA_W-1:0] fill_q, fill_d, wdata_q, pat_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              error_q, error_d, wren_q, busy_q, done_q, last;
  fill_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_pat (
    .mode_i(mode_d), .fill_value_i(fill_d), .idx_i(idx_d), .data_o(pat_d)
  );
  assign last = idx_q == LAST;
  // wdata_q always holds pattern(idx_q) outside IDLE, so CHECK compares against it directly
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    wcnt_d     = wcnt_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d    = WRITE;
        mode_d     = mode_e'(mode);
        fill_d     = fill_value;
        idx_d      = '0;
        retry_d    = '0;
        error_d    = 1'b0;
        err_addr_d = '0;
      end
      WRITE: if (VERIFY != 0) begin
        state_d = WAIT;
        wcnt_d  = '0;
      end else if (last) state_d = DONE;
      else idx_d = idx_q + 1'b1;
      WAIT: if (wcnt_q == WW'(RD_LAT - 1)) state_d = CHECK;
      else wcnt_d = wcnt_q + 1'b1;
      CHECK: if (mem_rdata == wdata_q) begin
        state_d = last ? DONE : WRITE;
        idx_d   = last ? idx_q : idx_q + 1'b1;
        retry_d = '0;
      end else if (retry_q < RW'(MAX_RETRY)) begin
        state_d = WRITE;
        retry_d = retry_q + 1'b1;
      end else state_d = FAIL;
      FAIL: begin
        state_d    = DONE;
        error_d    = 1'b1;
        err_addr_d = idx_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_IDENTITY;
      fill_q     <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      wcnt_q     <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      wcnt_q     <= wcnt_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      addr_q     <= state_d == IDLE ? '0 : idx_d;
      wdata_q    <= state_d == IDLE ? '0 : pat_d;
      wren_q     <= state_d == WRITE;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
    end
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;
endmodule
